// File: rtl/aec_pkg.sv
// Shared types and constants for the AEC evaluator scheduler.
package aec_pkg;

  typedef enum logic [2:0] {
    ARB,
    LOAD,
    SEND,
    WAIT,
    RESP,
    HOLD
  } state_e;

  localparam logic [7:0]  EQ    = 8'h3D;
  localparam logic [7:0]  NUL   = 8'h00;
  localparam int unsigned RES_W = 7;
  localparam int unsigned CHR_W = 8;

endpackage

// File: rtl/aec_rr_arb.sv
// Combinational round-robin pick: first active request at or after the pointer.
module aec_rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] j_idx;
    logic found;
    j         = 0;
    j_idx     = '0;
    found     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j     = (32'(ptr_i) + i) % N_REQ;
      j_idx = IDX_W'(j);
      if (!found && req_i[j_idx]) begin
        found            = 1'b1;
        gnt_oh_o[j_idx]  = 1'b1;
        gnt_idx_o        = j_idx;
      end
    end
  end

endmodule

// File: rtl/aec_sched.sv
// Round-robin scheduler sharing one AEC evaluator among N_REQ char-stream requesters.
// Optional WAIT watchdog enabled by defining AEC_SCHED_WDOG_EN.
module aec_sched
  import aec_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_vld,
  input  logic [CHR_W*N_REQ-1:0]     req_data,
  output logic [N_REQ-1:0]           req_rdy,
  output logic                       resp_valid,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [RES_W-1:0]           resp_result,
  output logic                       resp_err,
  output logic [CHR_W-1:0]           aec_ascii,
  output logic                       aec_ready,
  input  logic                       aec_valid,
  input  logic [RES_W-1:0]           aec_result
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
  localparam int unsigned AW    = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);
  localparam int unsigned HW    = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   sidx_q, sidx_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               used_q, used_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [HW-1:0]      hold_q, hold_d;
`ifdef AEC_SCHED_WDOG_EN
  localparam logic [9:0] WD_LAST = 10'd1022;
  logic [9:0]         wd_q, wd_d;
`endif

  logic [CHR_W-1:0]   buf_q [MAX_LEN];
  logic               buf_we;
  logic [AW-1:0]      wr_idx, rd_idx;

  logic [CHR_W-1:0]   req_chr [N_REQ];
  logic [N_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               hs;
  logic [CHR_W-1:0]   ch;
  logic               full;
  logic [IDX_W-1:0]   rr_nxt;

  for (genvar g = 0; g < N_REQ; g++) begin : g_chr
    assign req_chr[g] = req_data[g*CHR_W +: CHR_W];
  end

  aec_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (req_vld),
    .ptr_i     (rr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx)
  );

  assign hs     = (state_q == LOAD) && req_vld[gnt_q];
  assign ch     = req_chr[gnt_q];
  assign full   = (cnt_q == CNT_W'(MAX_LEN));
  assign wr_idx = cnt_q[AW-1:0];
  assign rd_idx = sidx_q[AW-1:0];
  assign rr_nxt = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      sidx_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      used_q  <= 1'b0;
      res_q   <= '0;
      hold_q  <= '0;
`ifdef AEC_SCHED_WDOG_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      sidx_q  <= sidx_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      used_q  <= used_d;
      res_q   <= res_d;
      hold_q  <= hold_d;
`ifdef AEC_SCHED_WDOG_EN
      wd_q    <= wd_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[wr_idx] <= ch;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    sidx_d  = sidx_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    used_d  = used_q;
    res_d   = res_q;
    hold_d  = hold_q;
    buf_we  = 1'b0;
`ifdef AEC_SCHED_WDOG_EN
    wd_d    = wd_q;
`endif
    unique case (state_q)
      ARB: begin
        if (|arb_oh) begin
          gnt_d   = arb_idx;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (hs) begin
          if (ch == EQ) begin
            if (ovf_q || (cnt_q == '0)) begin
              err_d   = 1'b1;
              used_d  = 1'b0;
              res_d   = '0;
              state_d = RESP;
            end else begin
              sidx_d  = '0;
              state_d = SEND;
            end
          end else if (full) begin
            // Buffer full: swallow the rest of the expression up to '='.
            ovf_d = 1'b1;
          end else begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      SEND: begin
        if (sidx_q == cnt_q) begin
          state_d = WAIT;
`ifdef AEC_SCHED_WDOG_EN
          wd_d    = '0;
`endif
        end else begin
          sidx_d = sidx_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (aec_valid) begin
          res_d   = aec_result;
          err_d   = 1'b0;
          used_d  = 1'b1;
          state_d = RESP;
        end
`ifdef AEC_SCHED_WDOG_EN
        // Counter value 1022 marks the 1023rd WAIT cycle without a result.
        else if (wd_q == WD_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          used_d  = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 10'd1;
        end
`endif
      end
      RESP: begin
        rr_d    = rr_nxt;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        hold_d  = '0;
        state_d = (used_q && (GAP_CYC != 0)) ? HOLD : ARB;
      end
      HOLD: begin
        if (hold_q == HW'(GAP_CYC - 1)) state_d = ARB;
        else                             hold_d  = hold_q + HW'(1);
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    req_rdy     = '0;
    resp_valid  = 1'b0;
    resp_id     = '0;
    resp_result = '0;
    resp_err    = 1'b0;
    aec_ascii   = NUL;
    aec_ready   = 1'b0;
    unique case (state_q)
      LOAD: req_rdy[gnt_q] = 1'b1;
      SEND: begin
        aec_ready = (sidx_q == '0);
        aec_ascii = (sidx_q == cnt_q) ? EQ : buf_q[rd_idx];
      end
      RESP: begin
        resp_valid  = 1'b1;
        resp_id     = gnt_q;
        resp_result = res_q;
        resp_err    = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aec_sched.sv
// Self-checking bench for aec_sched: vector table, scoreboard, evaluator model.
module tb_aec_sched;

  localparam int GAP    = 2;
  localparam int EV_LAT = 3;
  localparam int BUD    = 200;
  localparam logic [7:0] EQC = 8'h3D;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld [4];
  logic [7:0]  rd  [4];
  logic [3:0]  req_vld;
  logic [31:0] req_data;
  logic [3:0]  req_rdy;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [6:0]  resp_result;
  logic        resp_err;
  logic [7:0]  aec_ascii;
  logic        aec_ready;
  logic        aec_valid;
  logic [6:0]  aec_result;

  assign req_vld  = {vld[3], vld[2], vld[1], vld[0]};
  assign req_data = {rd[3], rd[2], rd[1], rd[0]};

  aec_sched #(.N_REQ(4), .MAX_LEN(16), .GAP_CYC(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_data    (req_data),
    .req_rdy     (req_rdy),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .aec_ascii   (aec_ascii),
    .aec_ready   (aec_ready),
    .aec_valid   (aec_valid),
    .aec_result  (aec_result)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int id; int res; bit err; } rsp_t;
  rsp_t sb[$];
  int   resp_cyc_id [4];
  int   first_rdy   [4];

  // Response monitor / scoreboard
  initial begin
    forever begin
      rsp_t e;
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        resp_cyc_id[resp_id] = cyc;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL resp_unexpected: got id %0d result %0d err %0d, expected none", resp_id, resp_result, resp_err);
        end else begin
          e = sb.pop_front();
          check("resp_id", 32'(resp_id), e.id);
          check("resp_result", 32'(resp_result), e.res);
          check("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end
  end

  // Evaluator model: records each burst, answers EV_LAT cycles after '='
  logic [7:0] got[$];
  int  ev_q[$];
  bit  cap = 0;
  int  cd = -1;
  int  ready_cnt = 0;
  int  stray_eq = 0;
  int  last_valid_cyc = -1000;
  int  last_gap = 0;
  int  eq_cyc = 0;

  initial begin
    aec_valid  = 1'b0;
    aec_result = '0;
    forever begin
      @(negedge clk);
      aec_valid = 1'b0;
      if (rst) begin
        cap = 0;
        cd  = -1;
      end else begin
        if (cd > 0) cd--;
        if (cd == 0) begin
          aec_valid      = 1'b1;
          last_valid_cyc = cyc;
          cd             = -1;
        end
        if (aec_ready) begin
          cap = 1;
          got.delete();
          ready_cnt++;
          last_gap = cyc - last_valid_cyc;
        end
        if (cap) begin
          got.push_back(aec_ascii);
          if (aec_ascii == EQC) begin
            cap    = 0;
            eq_cyc = cyc;
            if (ev_q.size() > 0) begin
              aec_result = 7'(ev_q.pop_front());
              cd         = EV_LAT;
            end
          end
        end else if (aec_ascii == EQC) begin
          stray_eq++;
        end
      end
    end
  end

  function automatic bit burst_ok(input string s);
    if (got.size() != s.len()) return 0;
    for (int k = 0; k < s.len(); k++) if (got[k] != s[k]) return 0;
    return 1;
  endfunction

  task automatic send_expr(input int id, input string s, input int stall);
    for (int k = 0; k < s.len(); k++) begin
      int t;
      bit acc;
      rd[id]  = s[k];
      vld[id] = 1'b1;
      t   = 0;
      acc = 0;
      while (!acc && t < BUD) begin
        @(negedge clk);
        acc = req_rdy[id];
        if (acc && k == 0) first_rdy[id] = cyc;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        n_vec++;
        n_err++;
        $display("FAIL req%0d_accept: char %0d not accepted within %0d cycles", id, k, BUD);
        vld[id] = 1'b0;
        return;
      end
      if (stall > 0 && k == 2) begin
        vld[id] = 1'b0;
        rd[id]  = 8'h00;
        repeat (stall) @(posedge clk);
        #1;
      end
    end
    vld[id] = 1'b0;
    rd[id]  = 8'h00;
  endtask

  task automatic wait_sb(input int bud, input string nm);
    int t;
    t = 0;
    while (sb.size() != 0 && t < bud) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0d responses outstanding, expected 0 after %0d cycles", nm, sb.size(), bud);
      sb.delete();
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  typedef struct { int id; string expr; int ev; int res; bit err; int stall; } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input int id, input string expr, input int ev, input int res,
                         input bit err, input int stall);
    vec_t v;
    v.id = id; v.expr = expr; v.ev = ev; v.res = res; v.err = err; v.stall = stall;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int rc0;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0;
      rd[i]  = 8'h00;
      resp_cyc_id[i] = 0;
      first_rdy[i]   = 0;
    end

    add_vec(0, "3+4*2=",             11, 11, 0, 0);
    add_vec(2, "12345678901234567=",  0,  0, 1, 0);
    add_vec(1, "=",                   0,  0, 1, 0);
    add_vec(3, "1234567890123456=",  99, 99, 0, 0);
    add_vec(2, "(1+2)=",              3,  3, 0, 4);
    add_vec(0, "9=",                  9,  9, 0, 0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_rdy",     32'(req_rdy), 0);
    check("rst_resp_valid",  32'(resp_valid), 0);
    check("rst_resp_id",     32'(resp_id), 0);
    check("rst_resp_result", 32'(resp_result), 0);
    check("rst_resp_err",    32'(resp_err), 0);
    check("rst_aec_ascii",   32'(aec_ascii), 0);
    check("rst_aec_ready",   32'(aec_ready), 0);
    @(posedge clk);
    #1;

    // Req1 and req3 together with pointer 0: req1 first, then req3 after HOLD
    sb.push_back('{1, 2, 1'b0});
    sb.push_back('{3, 6, 1'b0});
    ev_q.push_back(2);
    ev_q.push_back(6);
    fork
      send_expr(1, "1+1=", 0);
      send_expr(3, "2*3=", 0);
    join
    wait_sb(300, "rr_pair");
    check("rr_resp_to_next_load", 32'(first_rdy[3] - resp_cyc_id[1]), 32'(GAP + 2));
    check("rr_gap_ok", 32'(last_gap >= GAP + 1), 1);
    check("rr_burst2", 32'(burst_ok("2*3=")), 1);

    for (int v = 0; v < tbl.size(); v++) begin
      rc0 = ready_cnt;
      if (!tbl[v].err) ev_q.push_back(tbl[v].ev);
      sb.push_back('{tbl[v].id, tbl[v].res, tbl[v].err});
      send_expr(tbl[v].id, tbl[v].expr, tbl[v].stall);
      wait_sb(BUD, "vec_resp");
      check("vec_ready_strobes", 32'(ready_cnt - rc0), tbl[v].err ? 0 : 1);
      if (!tbl[v].err) check("vec_burst", 32'(burst_ok(tbl[v].expr)), 1);
      check("vec_idle_ascii", 32'(aec_ascii), 0);
    end

    // Reset on SEND cycle 2 drops the job; a fresh one still works
    send_expr(0, "(1+2)=", 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("send2_ascii", 32'(aec_ascii), 32'(8'h2B));
    check("send2_ready", 32'(aec_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outputs",
          32'({req_rdy, resp_valid, resp_id, resp_result, resp_err, aec_ascii, aec_ready}), 0);
    repeat (20) @(posedge clk);
    #1;
    rc0 = ready_cnt;
    sb.push_back('{0, 3, 1'b0});
    ev_q.push_back(3);
    send_expr(0, "(1+2)=", 0);
    wait_sb(BUD, "post_rst_resp");
    check("post_rst_strobes", 32'(ready_cnt - rc0), 1);
    check("post_rst_burst", 32'(burst_ok("(1+2)=")), 1);

`ifdef AEC_SCHED_WDOG_EN
    sb.push_back('{1, 0, 1'b1});
    send_expr(1, "5=", 0);
    wait_sb(1200, "wdog_resp");
    check("wdog_latency", 32'(resp_cyc_id[1] - eq_cyc), 1024);
`endif

    check("stray_eq", 32'(stray_eq), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
